// File: rtl/tetris_vga_renderer_if.sv
// Playfield bus from the game FSM and the VGA signals produced by the renderer.
interface tetris_vga_renderer_if;
  logic [239:0] data;
  logic [3:0]   red;
  logic [3:0]   green;
  logic [3:0]   blue;
  logic         hsync;
  logic         vsync;
  logic         frame_tick;

  modport master (output data, input red, green, blue, hsync, vsync, frame_tick);
  modport slave  (input data, output red, green, blue, hsync, vsync, frame_tick);
endinterface

// File: rtl/tetris_vga_renderer.sv
// 640x480@60 VGA renderer for the 12x20 Tetris playfield, 25 MHz pixel tick from a 50 MHz clk.
// Field data is snapshotted once per frame on entry to vertical blanking.
module tetris_vga_renderer #(
  parameter int          H_ACTIVE = 640,
  parameter int          H_FP     = 16,
  parameter int          H_SYNC   = 96,
  parameter int          H_BP     = 48,
  parameter int          V_ACTIVE = 480,
  parameter int          V_FP     = 10,
  parameter int          V_SYNC   = 2,
  parameter int          V_BP     = 33,
  parameter int          CELL     = 20,
  parameter int          X0       = 200,
  parameter int          Y0       = 40,
  parameter int          BORDER   = 4,
  parameter logic [11:0] FILL_RGB = 12'h0FF,
  parameter logic [11:0] EDGE_RGB = 12'h088,
  parameter logic [11:0] BORD_RGB = 12'hFFF,
  parameter logic [11:0] BG_RGB   = 12'h000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  tetris_vga_renderer_if.slave  bus
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] HA     = 10'(H_ACTIVE);
  localparam logic [9:0] VA     = 10'(V_ACTIVE);
  localparam logic [9:0] HS_LO  = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_HI  = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_LO  = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_HI  = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [9:0] SNAP_V = 10'(V_ACTIVE - 1);
  localparam logic [9:0] FX_LO  = 10'(X0);
  localparam logic [9:0] FX_HI  = 10'(X0 + 12 * CELL);
  localparam logic [9:0] FY_LO  = 10'(Y0);
  localparam logic [9:0] FY_HI  = 10'(Y0 + 20 * CELL);
  localparam logic [9:0] BX_LO  = 10'(X0 - BORDER);
  localparam logic [9:0] BX_HI  = 10'(X0 + 12 * CELL + BORDER);
  localparam logic [9:0] BY_LO  = 10'(Y0 - BORDER);
  localparam logic [9:0] BY_HI  = 10'(Y0 + 20 * CELL + BORDER);
  localparam logic [4:0] SUB_LAST = 5'(CELL - 1);

  logic         pix_en_reg;
  logic [9:0]   hcnt_reg, hcnt_next;
  logic [9:0]   vcnt_reg, vcnt_next;
  logic [3:0]   col_reg, col_next;
  logic [4:0]   subx_reg, subx_next;
  logic [4:0]   row_reg, row_next;
  logic [4:0]   suby_reg, suby_next;
  logic [239:0] snap_reg;
  logic [11:0]  rgb_reg, rgb_next;
  logic         hsync_reg, hsync_next;
  logic         vsync_reg, vsync_next;
  logic         frame_tick_reg;

  logic         h_wrap;
  logic         snap_take;
  logic         active, in_field, in_border, occupied, ring;
  logic [11:0]  cur_row;
  logic [11:0]  rows [20];

  genvar gi;
  generate
    for (gi = 0; gi < 20; gi++) begin : g_rows
      assign rows[gi] = snap_reg[gi*12 +: 12];
    end
  endgenerate

  // Counter advance; the cell counter pairs replace a divide by CELL.
  always_comb begin
    h_wrap    = (hcnt_reg == H_LAST);
    hcnt_next = h_wrap ? 10'd0 : hcnt_reg + 10'd1;
    vcnt_next = vcnt_reg;
    if (h_wrap)
      vcnt_next = (vcnt_reg == V_LAST) ? 10'd0 : vcnt_reg + 10'd1;

    col_next  = col_reg;
    subx_next = subx_reg;
    if (hcnt_next == FX_LO) begin
      col_next  = 4'd0;
      subx_next = 5'd0;
    end else if (subx_reg == SUB_LAST) begin
      col_next  = col_reg + 4'd1;
      subx_next = 5'd0;
    end else begin
      subx_next = subx_reg + 5'd1;
    end

    row_next  = row_reg;
    suby_next = suby_reg;
    if (h_wrap) begin
      if (vcnt_next == FY_LO) begin
        row_next  = 5'd0;
        suby_next = 5'd0;
      end else if (suby_reg == SUB_LAST) begin
        row_next  = row_reg + 5'd1;
        suby_next = 5'd0;
      end else begin
        suby_next = suby_reg + 5'd1;
      end
    end

    snap_take = h_wrap && (vcnt_reg == SNAP_V);
  end

  always_comb begin
    active    = (hcnt_reg < HA) && (vcnt_reg < VA);
    in_field  = (hcnt_reg >= FX_LO) && (hcnt_reg < FX_HI) &&
                (vcnt_reg >= FY_LO) && (vcnt_reg < FY_HI);
    in_border = (hcnt_reg >= BX_LO) && (hcnt_reg < BX_HI) &&
                (vcnt_reg >= BY_LO) && (vcnt_reg < BY_HI);
    cur_row   = (row_reg < 5'd20) ? rows[row_reg] : 12'd0;
    occupied  = (col_reg < 4'd12) && cur_row[4'd11 - col_reg];
    ring      = (subx_reg == 5'd0) || (subx_reg == SUB_LAST) ||
                (suby_reg == 5'd0) || (suby_reg == SUB_LAST);

    rgb_next = BG_RGB;
    if (!active)
      rgb_next = 12'h000;
    else if (in_field)
      rgb_next = occupied ? (ring ? EDGE_RGB : FILL_RGB) : BG_RGB;
    else if (in_border)
      rgb_next = BORD_RGB;

    hsync_next = !((hcnt_reg >= HS_LO) && (hcnt_reg < HS_HI));
    vsync_next = !((vcnt_reg >= VS_LO) && (vcnt_reg < VS_HI));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_en_reg     <= 1'b0;
      hcnt_reg       <= 10'd0;
      vcnt_reg       <= 10'd0;
      col_reg        <= 4'd0;
      subx_reg       <= 5'd0;
      row_reg        <= 5'd0;
      suby_reg       <= 5'd0;
      snap_reg       <= '0;
      rgb_reg        <= 12'h000;
      hsync_reg      <= 1'b1;
      vsync_reg      <= 1'b1;
      frame_tick_reg <= 1'b0;
    end else begin
      pix_en_reg     <= ~pix_en_reg;
      frame_tick_reg <= pix_en_reg && snap_take;
      if (pix_en_reg) begin
        hcnt_reg  <= hcnt_next;
        vcnt_reg  <= vcnt_next;
        col_reg   <= col_next;
        subx_reg  <= subx_next;
        row_reg   <= row_next;
        suby_reg  <= suby_next;
        rgb_reg   <= rgb_next;
        hsync_reg <= hsync_next;
        vsync_reg <= vsync_next;
        if (snap_take)
          snap_reg <= bus.data;
      end
    end
  end

  assign bus.red        = rgb_reg[11:8];
  assign bus.green      = rgb_reg[7:4];
  assign bus.blue       = rgb_reg[3:0];
  assign bus.hsync      = hsync_reg;
  assign bus.vsync      = vsync_reg;
  assign bus.frame_tick = frame_tick_reg;

endmodule
